mips_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of `mips_decode`. It holds the PC, issues word reads to instruction memory over a valid/ready request channel, buffers in-order responses in a small FIFO, and presents each instruction with its PC and pre-sliced `dcd_op`/`dcd_funct2` fields to decode over a valid/ready handshake. Redirects flush all younger work. A halt request, driven by decode's `ctrl_Sys`, stops fetch permanently until reset.

---
 rtl/mips_fetch.sv | 138 +++++++++++++
 tb/tb_mips_fetch.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mips_fetch.sv
// Instruction fetch stage: PC, credit-limited imem request channel, in-order
// response FIFO and valid/ready delivery to decode, with redirect flush and halt.
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fet_valid,
    input  logic        fet_ready,
    output logic [31:0] fet_inst,
    output logic [31:0] fet_pc,
    output logic [5:0]  dcd_op,
    output logic [5:0]  dcd_funct2,
    output logic        fet_halted
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t         state_r, state_s;
    logic [31:0]    pc_r, pc_s;
    logic [31:0]    tag_r, tag_s;
    logic [CW-1:0]  inflight_r, inflight_s;
    logic [CW-1:0]  occ_r, occ_s;
    logic [CW-1:0]  drop_r, drop_s;
    logic [PW-1:0]  wr_ptr_r, wr_ptr_s;
    logic [PW-1:0]  rd_ptr_r, rd_ptr_s;
    logic           req_valid_r, req_valid_s;
    logic           halted_r, halted_s;
    logic [63:0]    fifo_r [DEPTH];

    logic accept_s, resp_s, drop_hit_s, enq_s, deq_s, redir_s;

    // Next-state logic: FSM, credit counters, PC/tag and FIFO pointers
    always_comb begin
        accept_s   = req_valid_r && imem_req_ready;
        // a response with nothing outstanding cannot be ours; ignore it
        resp_s     = imem_resp_valid && (inflight_r != {CW{1'b0}});
        deq_s      = fet_valid && fet_ready;
        redir_s    = (state_r == RUN) && redirect_valid && !halt;
        drop_hit_s = resp_s && (drop_r != {CW{1'b0}});
        enq_s      = resp_s && !drop_hit_s && !redir_s;
        state_s    = state_r;
        inflight_s = inflight_r + CW'(accept_s) - CW'(resp_s);

        case (state_r)
            RUN: begin
                if (halt) begin
                    state_s = HALTED;
                end else begin
                    state_s = RUN;
                end
            end
            HALTED:  state_s = HALTED;
            default: state_s = RUN;
        endcase

        if (redir_s) begin
            // everything requested so far, including this cycle's accept, is stale
            pc_s     = {redirect_pc[31:2], 2'b00};
            tag_s    = {redirect_pc[31:2], 2'b00};
            drop_s   = inflight_s;
            occ_s    = {CW{1'b0}};
            wr_ptr_s = {PW{1'b0}};
            rd_ptr_s = {PW{1'b0}};
        end else begin
            pc_s     = accept_s ? pc_r + 32'd4 : pc_r;
            tag_s    = enq_s ? tag_r + 32'd4 : tag_r;
            drop_s   = drop_r - CW'(drop_hit_s);
            occ_s    = occ_r + CW'(enq_s) - CW'(deq_s);
            wr_ptr_s = wr_ptr_r + PW'(enq_s);
            rd_ptr_s = rd_ptr_r + PW'(deq_s);
        end

        req_valid_s = (state_s == RUN) &&
                      (({1'b0, inflight_s} + {1'b0, occ_s}) < {1'b0, DEPTH_C});
        halted_s    = (state_s == HALTED) && (inflight_s == {CW{1'b0}}) &&
                      (occ_s == {CW{1'b0}});
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r     <= RUN;
            pc_r        <= RESET_PC;
            tag_r       <= RESET_PC;
            inflight_r  <= {CW{1'b0}};
            occ_r       <= {CW{1'b0}};
            drop_r      <= {CW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            req_valid_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            tag_r       <= tag_s;
            inflight_r  <= inflight_s;
            occ_r       <= occ_s;
            drop_r      <= drop_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            req_valid_r <= req_valid_s;
            halted_r    <= halted_s;
        end
    end

    // FIFO storage of {instruction, pc}
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= 64'd0;
            end
        end else if (enq_s) begin
            fifo_r[wr_ptr_r] <= {imem_resp_data, tag_r};
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    assign fet_valid      = (occ_r != {CW{1'b0}});
    assign fet_inst       = fifo_r[rd_ptr_r][63:32];
    assign fet_pc         = fifo_r[rd_ptr_r][31:0];
    assign dcd_op         = fet_inst[31:26];
    assign dcd_funct2     = fet_inst[5:0];
    assign fet_halted     = halted_r;
endmodule

// File: tb/tb_mips_fetch.sv
// Randomized bench for mips_fetch: in-order memory model plus a scoreboard of
// the instruction/PC stream decode must see, checked by an independent monitor.
module tb_mips_fetch;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic        fet_valid, fet_ready = 1'b0;
    logic [31:0] fet_inst, fet_pc;
    logic [5:0]  dcd_op, dcd_funct2;
    logic        fet_halted;

    always #5 clk = ~clk;

    mips_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_b(rst_b),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .fet_valid(fet_valid), .fet_ready(fet_ready), .fet_inst(fet_inst),
        .fet_pc(fet_pc), .dcd_op(dcd_op), .dcd_funct2(dcd_funct2),
        .fet_halted(fet_halted)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; int due; bit live; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    req_t        memq[$];   // requests the memory has accepted and not yet answered
    exp_t        expq[$];   // words decode must still receive, in order
    logic [31:0] exp_pc;
    bit          halted_m = 1'b0, fresh = 1'b0, checking = 1'b0;
    int          cyc = 0, n_cmp = 0, n_bad = 0;
    int          p_mready = 100, p_fready = 100, p_redir = 0, max_lat = 1;
    bit          force_redir = 1'b0, do_halt = 1'b0;
    logic [31:0] force_target = 32'd0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endfunction

    // Monitor: compares what decode sees against the scoreboard head
    always @(negedge clk) begin
        if (checking) begin
            check("req_valid", imem_req_valid,
                  !fresh && !halted_m && ((memq.size() + expq.size()) < DEPTH));
            check("fet_halted", fet_halted,
                  halted_m && memq.size() == 0 && expq.size() == 0);
            check("fet_valid", fet_valid, expq.size() != 0);
            if (fet_valid && expq.size() != 0) begin
                check("fet_word", {fet_inst, fet_pc, dcd_op, dcd_funct2},
                      {expq[0].inst, expq[0].pc, expq[0].inst[31:26], expq[0].inst[5:0]});
                if (fet_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic step();
        req_t r;
        @(posedge clk); #2;
        imem_req_ready = ($urandom_range(99) < p_mready);
        fet_ready      = ($urandom_range(99) < p_fready);
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memq[0].data;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        redirect_valid = force_redir || ($urandom_range(99) < p_redir);
        redirect_pc    = force_redir ? force_target : $urandom;
        halt           = do_halt;
        @(negedge clk); #1;
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            r.addr = exp_pc;
            r.data = $urandom;
            r.due  = cyc + int'($urandom_range(max_lat, 1));
            r.live = 1'b1;
            memq.push_back(r);
            exp_pc = exp_pc + 32'd4;
        end
        if (imem_resp_valid) begin
            if (memq[0].live) expq.push_back('{pc: memq[0].addr, inst: memq[0].data});
            void'(memq.pop_front());
        end
        if (redirect_valid && !halt && !halted_m) begin
            foreach (memq[i]) memq[i].live = 1'b0;
            expq.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
        end
        if (halt) halted_m = 1'b1;
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_b = 1'b0;
        checking = 1'b0;
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_fet_valid", fet_valid, 1'b0);
        check("rst_fet_word", {fet_inst, fet_pc, dcd_op, dcd_funct2}, 76'd0);
        check("rst_halted", fet_halted, 1'b0);
        memq.delete();
        expq.delete();
        exp_pc = RESET_PC;
        halted_m = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        halt = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_b = 1'b1;
        fresh = 1'b1;
        checking = 1'b1;
        @(negedge clk); #1;
        fresh = 1'b0;
        cyc++;
    endtask

    initial begin
        do_reset();
        // streaming with ideal memory and decode
        repeat (40) step();
        // decode stall
        p_fready = 0;
        repeat (5) step();
        p_fready = 100;
        repeat (10) step();
        // random traffic with random redirects
        p_mready = 70; p_fready = 60; p_redir = 5; max_lat = 3;
        repeat (400) step();
        // directed redirect to an unaligned target while requests are in flight
        p_mready = 100; p_fready = 100; p_redir = 0; max_lat = 1;
        repeat (5) step();
        force_redir = 1'b1; force_target = 32'h0040_0103;
        step();
        force_redir = 1'b0;
        repeat (10) step();
        // PC wrap at the top of the address space
        force_redir = 1'b1; force_target = 32'hFFFF_FFF4;
        step();
        force_redir = 1'b0;
        repeat (12) step();
        // asynchronous reset in the middle of traffic
        p_mready = 70; p_fready = 60; p_redir = 5; max_lat = 3;
        repeat (30) step();
        do_reset();
        p_redir = 0;
        repeat (20) step();
        // halt together with a redirect: redirect ignored, in-flight work drains
        force_redir = 1'b1; force_target = 32'h1234_5678; do_halt = 1'b1;
        step();
        force_redir = 1'b0; do_halt = 1'b0; p_fready = 100; p_mready = 100;
        for (int i = 0; i < 100 && !(memq.size() == 0 && expq.size() == 0); i++) step();
        check("drain_done", (memq.size() == 0 && expq.size() == 0), 1'b1);
        repeat (2) step();
        check("halted_final", fet_halted, 1'b1);
        repeat (10) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
